// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage pipelined bitwise logic unit with accumulator, flags and result counter
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   input  logic             acc_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             zero,
   output logic             parity,
   output logic [CNT_W-1:0] op_count
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [2:0]       s1_sel;
   logic             s1_acc_mode;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] r;
   logic             s1_move;
   logic             deliver;

   assign s1_move  = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || s1_move;
   assign deliver  = out_valid && out_ready;

   // Result of the S1 operation; acc is sampled here so chained ops see the previous result
   always_comb begin
      op_a = s1_acc_mode ? acc : s1_a;
      r    = '0;
      case (s1_sel)
         3'b000:  r = ~op_a;
         3'b001:  r = op_a & s1_b;
         3'b010:  r = ~(op_a & s1_b);
         3'b011:  r = op_a ^ s1_b;
         3'b100:  r = ~(op_a ^ s1_b);
         3'b101:  r = op_a | s1_b;
         3'b110:  r = ~(op_a | s1_b);
         default: r = op_a;
      endcase
   end

   // S1 input register: capture on accept, drain when the operation moves to S2
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid    <= 1'b0;
         s1_a        <= '0;
         s1_b        <= '0;
         s1_sel      <= '0;
         s1_acc_mode <= 1'b0;
      end else if (in_valid && in_ready) begin
         s1_valid    <= 1'b1;
         s1_a        <= a;
         s1_b        <= b;
         s1_sel      <= sel;
         s1_acc_mode <= acc_mode;
      end else if (s1_move) begin
         s1_valid    <= 1'b0;
      end
   end

   // S2 output register and accumulator: load on transfer, hold under backpressure
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         s         <= '0;
         zero      <= 1'b0;
         parity    <= 1'b0;
         acc       <= '0;
      end else if (s1_move) begin
         out_valid <= 1'b1;
         s         <= r;
         zero      <= (r == '0);
         parity    <= ^r;
         acc       <= r;
      end else if (deliver) begin
         out_valid <= 1'b0;
      end
   end

   // Count delivered results, wrapping naturally at the counter width
   always_ff @(posedge clk) begin
      if (reset) begin
         op_count <= '0;
      end else if (deliver) begin
         op_count <= op_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - randomized and directed self-checking bench for logic_unit_pipe
module tb_logic_unit_pipe;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [2:0] sel = '0;
   logic       acc_mode = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] s;
   logic       zero;
   logic       parity;
   logic [3:0] op_count;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sel(sel), .acc_mode(acc_mode),
      .out_valid(out_valid), .out_ready(out_ready), .s(s),
      .zero(zero), .parity(parity), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Reference model: results computed in acceptance order with a running accumulator
   bit         m_s1v = 0;
   logic [7:0] m_s1r = '0;
   bit         m_ov = 0;
   logic [7:0] m_s = '0;
   bit         m_z = 0;
   bit         m_p = 0;
   logic [7:0] m_acc = '0;
   logic [3:0] m_cnt = '0;
   bit         last_acc = 0;
   int         n_acc = 0;
   logic [7:0] dq[$];

   function automatic logic [7:0] op(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
      case (f)
         3'd0: return 8'hFF - x;
         3'd1: return x & y;
         3'd2: return 8'hFF - (x & y);
         3'd3: return x ^ y;
         3'd4: return 8'hFF - (x ^ y);
         3'd5: return x | y;
         3'd6: return 8'hFF - (x | y);
         default: return x;
      endcase
   endfunction

   function automatic bit model_ready();
      return !m_s1v || (!m_ov || out_ready);
   endfunction

   always @(posedge clk) begin
      bit mv;
      bit rdy;
      logic [7:0] r;
      last_acc = 0;
      if (reset) begin
         m_s1v = 0; m_ov = 0; m_s = '0; m_z = 0; m_p = 0; m_acc = '0; m_cnt = '0;
      end else begin
         mv  = m_s1v && (!m_ov || out_ready);
         rdy = model_ready();
         if (m_ov && out_ready) begin
            m_cnt = m_cnt + 4'd1;
            dq.push_back(m_s);
         end
         if (mv) begin
            m_s = m_s1r; m_z = (m_s1r == 8'h00); m_p = ($countones(m_s1r) % 2) == 1; m_ov = 1;
         end else if (m_ov && out_ready) begin
            m_ov = 0;
         end
         if (in_valid && rdy) begin
            r = op(sel, acc_mode ? m_acc : a, b);
            m_acc = r; m_s1r = r; m_s1v = 1; last_acc = 1; n_acc++;
         end else if (mv) begin
            m_s1v = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison of every DUT output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", 32'(in_ready), 32'(model_ready()));
         chk("out_valid", 32'(out_valid), 32'(m_ov));
         chk("s", 32'(s), 32'(m_s));
         chk("zero", 32'(zero), 32'(m_z));
         chk("parity", 32'(parity), 32'(m_p));
         chk("op_count", 32'(op_count), 32'(m_cnt));
      end
   end

   task automatic send(input logic [7:0] ta, input logic [7:0] tb2, input logic [2:0] ts, input logic tacc);
      int n = 0;
      a = ta; b = tb2; sel = ts; acc_mode = tacc; in_valid = 1'b1;
      do begin
         @(posedge clk); #1; n++;
      end while (!last_acc && n < 50);
      if (!last_acc) chk("send_timeout", 32'(n), 32'd0);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic expect_dq(input string name, input logic [7:0] exp[], input int n);
      chk({name, "_count"}, 32'(dq.size()), 32'(n));
      for (int i = 0; i < n && i < dq.size(); i++)
         chk(name, 32'(dq[i]), 32'(exp[i]));
   endtask

   initial begin
      logic [7:0] e[];
      int base;
      reset = 1'b1; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_en = 1'b1;

      // op sweep
      dq.delete();
      for (int i = 0; i < 8; i++) send(8'hF0, 8'h3C, 3'(i), 1'b0);
      repeat (3) @(posedge clk); #1;
      e = '{8'h0F, 8'h30, 8'hCF, 8'hCC, 8'h33, 8'hFC, 8'h03, 8'hF0};
      expect_dq("sweep", e, 8);

      // flags
      dq.delete();
      send(8'hF0, 8'h0F, 3'b001, 1'b0);
      send(8'h01, 8'h00, 3'b101, 1'b0);
      repeat (3) @(posedge clk); #1;
      e = '{8'h00, 8'h01};
      expect_dq("flags", e, 2);

      // accumulator chain
      dq.delete();
      send(8'h5A, 8'h00, 3'b111, 1'b0);
      send(8'h00, 8'hFF, 3'b011, 1'b1);
      send(8'h00, 8'h0F, 3'b001, 1'b1);
      repeat (3) @(posedge clk); #1;
      e = '{8'h5A, 8'hA5, 8'h05};
      expect_dq("acc_chain", e, 3);

      // backpressure
      do_reset();
      dq.delete();
      out_ready = 1'b0;
      base = n_acc;
      fork
         begin
            send(8'h11, 8'h00, 3'b111, 1'b0);
            send(8'h22, 8'h00, 3'b111, 1'b0);
            send(8'h33, 8'h00, 3'b111, 1'b0);
            send(8'h44, 8'h00, 3'b111, 1'b0);
         end
         begin
            repeat (4) @(posedge clk); #1;
            chk("bp_accepts", 32'(n_acc - base), 32'd2);
            out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk); #1;
      e = '{8'h11, 8'h22, 8'h33, 8'h44};
      expect_dq("bp_order", e, 4);
      chk("bp_count", 32'(m_cnt), 32'd4);

      // counter wrap
      do_reset();
      for (int i = 0; i < 17; i++) send(8'(i), 8'h55, 3'(i), 1'b0);
      repeat (3) @(posedge clk); #1;
      chk("wrap_count", 32'(m_cnt), 32'd1);

      // reset with both stages full
      out_ready = 1'b0;
      send(8'h77, 8'h00, 3'b111, 1'b0);
      send(8'h66, 8'h00, 3'b111, 1'b0);
      do_reset();
      chk("rst_ov", 32'(m_ov), 32'd0);
      out_ready = 1'b1;
      dq.delete();
      send(8'hAB, 8'h00, 3'b111, 1'b1);
      repeat (3) @(posedge clk); #1;
      e = '{8'h00};
      expect_dq("rst_acc", e, 1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a = 8'($urandom); b = 8'($urandom);
         sel = 3'($urandom); acc_mode = 1'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk); #1;

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
